restoring_divider: RTL and testbench
====================================

# restoring_divider

Multi-cycle unsigned integer divider: computes quotient and remainder of two BUS_WIDTH-bit operands by restoring shift-and-subtract, one quotient bit per clock. It is the inverse companion to the combinational arithmetic blocks in the arithmetics library: a sequential datapath built around a (BUS_WIDTH+1)-bit subtractor. A start/busy/done handshake lets a controller issue one division at a time.

## Interface
- BUS_WIDTH, 8, operand, quotient and remainder width (≥2)
- i_clk  input  1  clock; all state changes on rising edge
- i_rst_n  input  1  reset, asynchronous, active-low
- i_start  input  1  request; sampled only in IDLE
- i_dividend  input  BUS_WIDTH  unsigned dividend; captured on accepted start
- i_divisor  input  BUS_WIDTH  unsigned divisor; captured on accepted start
- o_busy  output  1  high in CALC and DONE
- o_done  output  1  one-cycle pulse; results valid and newly updated
- o_quotient  output  BUS_WIDTH  registered quotient
- o_remainder  output  BUS_WIDTH  registered remainder
- o_div_by_zero  output  1  registered; set when captured divisor was 0

## Operation
- States: IDLE, CALC, DONE. Reset state IDLE.
- Reset (i_rst_n low, asynchronous): state IDLE, iteration counter 0, internal registers 0, o_busy=0, o_done=0, o_quotient=0, o_remainder=0, o_div_by_zero=0. Reset mid-division discards the operation; no o_done is produced for it.
- IDLE: i_start=1 at an edge → capture dividend into shift register Q, divisor into D, clear partial remainder R (BUS_WIDTH+1 bits), counter=BUS_WIDTH-1, go CALC. i_start=0 → stay.
- CALC, each edge: T = {R[BUS_WIDTH-1:0], Q[BUS_WIDTH-1]}; diff = T − {1'b0, D}, (BUS_WIDTH+1)-bit unsigned. If diff MSB = 0 (no borrow): R=diff, Q={Q[BUS_WIDTH-2:0],1}; else R=T, Q={Q[BUS_WIDTH-2:0],0}. Counter=0 → go DONE, else decrement.
- Entering DONE (same edge as last iteration): o_quotient=final Q, o_remainder=final R[BUS_WIDTH-1:0], o_div_by_zero=(D==0), o_done=1.
- DONE: next edge → IDLE, o_done=0.
- Divisor 0: no special path; algorithm yields quotient all ones, remainder = dividend; o_div_by_zero=1. Same latency.
- i_start ignored in CALC and DONE (no queuing); captured operands unaffected by input changes after acceptance.
- o_quotient/o_remainder/o_div_by_zero hold value until the next completion or reset.
- Invariant for divisor≠0: dividend = quotient·divisor + remainder, remainder < divisor.

## Timing
- Start accepted at edge N → o_busy=1 after edge N.
- Iterations at edges N+1 … N+BUS_WIDTH; o_done=1 and results updated after edge N+BUS_WIDTH.
- o_done falls, o_busy falls after edge N+BUS_WIDTH+1; earliest next acceptance at edge N+BUS_WIDTH+2 → throughput one division per BUS_WIDTH+2 cycles.
- All outputs registered; no combinational input-to-output path.
- i_start held high continuously → back-to-back divisions at maximum throughput, each capturing operands present at its accepting edge.

## Test plan
- BUS_WIDTH=8, start with 100/7 at edge N → o_done pulse exactly after edge N+8, quotient=14, remainder=2, div_by_zero=0; o_busy high for 9 cycles.
- 255/1 → quotient=255, remainder=0; 3/10 → quotient=0, remainder=3; 200/200 → quotient=1, remainder=0.
- 5/0 → quotient=255, remainder=5, div_by_zero=1 with same latency; following 9/3 → quotient=3, remainder=0, div_by_zero=0.
- Start 100/7, then pulse i_start with 50/5 and change operand inputs during CALC → ignored; result 14/2, single o_done.
- Assert i_rst_n low mid-CALC (after 4 iterations) → all outputs 0 immediately, no o_done; after release, 77/4 → quotient=19, remainder=1.
- i_start held high with random operands for 1000 divisions → each completes in 8 cycles after acceptance, 10 cycles apart, all satisfy quotient·divisor+remainder=dividend against model.

Source files
------------

// File: rtl/restoring_divider.sv
// Sequential unsigned divider: restoring shift-and-subtract, one quotient bit
// per clock, with a start/busy/done handshake.
module restoring_divider #(
  parameter int BUS_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [BUS_WIDTH-1:0] i_dividend,
  input  logic [BUS_WIDTH-1:0] i_divisor,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [BUS_WIDTH-1:0] o_quotient,
  output logic [BUS_WIDTH-1:0] o_remainder,
  output logic                 o_div_by_zero
);

  localparam int CNT_W = $clog2(BUS_WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state_reg, state_next;
  logic [BUS_WIDTH-1:0] q_reg, d_reg;
  logic [BUS_WIDTH:0]   r_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic                 busy_reg, done_reg, dbz_reg;
  logic [BUS_WIDTH-1:0] quotient_reg, remainder_reg;

  logic [BUS_WIDTH:0]   trial, diff, r_next;
  logic [BUS_WIDTH-1:0] q_next;
  logic                 last_iter;

  // Shift the next dividend bit into the partial remainder and try subtracting.
  assign trial     = {r_reg[BUS_WIDTH-1:0], q_reg[BUS_WIDTH-1]};
  assign diff      = trial - {1'b0, d_reg};
  assign last_iter = (cnt_reg == '0);

  always_comb begin
    q_next = {q_reg[BUS_WIDTH-2:0], ~diff[BUS_WIDTH]};
    r_next = diff[BUS_WIDTH] ? trial : diff;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (i_start) state_next = CALC;
      CALC:    if (last_iter) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= (state_next != IDLE);
      done_reg  <= (state_reg == CALC) && last_iter;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      q_reg         <= '0;
      d_reg         <= '0;
      r_reg         <= '0;
      cnt_reg       <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (i_start) begin
            q_reg   <= i_dividend;
            d_reg   <= i_divisor;
            r_reg   <= '0;
            cnt_reg <= CNT_W'(BUS_WIDTH - 1);
          end
        end
        CALC: begin
          q_reg <= q_next;
          r_reg <= r_next;
          if (last_iter) begin
            quotient_reg  <= q_next;
            remainder_reg <= r_next[BUS_WIDTH-1:0];
            dbz_reg       <= (d_reg == '0);
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy        = busy_reg;
  assign o_done        = done_reg;
  assign o_quotient    = quotient_reg;
  assign o_remainder   = remainder_reg;
  assign o_div_by_zero = dbz_reg;

endmodule

// File: tb/tb_restoring_divider.sv
// Scoreboard bench for restoring_divider: stimulus pushes expected results,
// a negedge monitor pops and compares on every o_done pulse.
module tb_restoring_divider;

  localparam int BW = 8;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic [BW-1:0] i_dividend = '0;
  logic [BW-1:0] i_divisor = '0;
  logic          o_busy, o_done, o_div_by_zero;
  logic [BW-1:0] o_quotient, o_remainder;

  restoring_divider #(.BUS_WIDTH(BW)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_dividend   (i_dividend),
    .i_divisor    (i_divisor),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_quotient   (o_quotient),
    .o_remainder  (o_remainder),
    .o_div_by_zero(o_div_by_zero)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int a, b, q, r, dz, acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_count = 0;
  int   last_acc = -1;

  always @(posedge i_clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: one line per completed transaction.
  always @(negedge i_clk) begin
    if (i_rst_n && o_done) begin
      exp_t e;
      done_count++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done with empty scoreboard (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        $display("div %0d/%0d -> q=%0d r=%0d dz=%0d (cycle %0d)",
                 e.a, e.b, o_quotient, o_remainder, o_div_by_zero, cyc);
        check("quotient", int'(o_quotient), e.q);
        check("remainder", int'(o_remainder), e.r);
        check("div_by_zero", int'(o_div_by_zero), e.dz);
        check("latency", cyc - e.acc, BW);
        if (e.b != 0)
          check("invariant", int'(o_quotient) * e.b + int'(o_remainder), e.a);
      end
    end
  end

  task automatic wait_idle();
    int w = 0;
    while (o_busy && w < 40) begin
      @(negedge i_clk);
      w++;
    end
    if (o_busy) check("idle_timeout", 1, 0);
  endtask

  // Issue one division from a negedge; returns at the negedge after acceptance.
  task automatic issue(input int a, input int b, input int q, input int r,
                       input int dz, input bit track);
    exp_t e;
    wait_idle();
    i_start    = 1'b1;
    i_dividend = BW'(a);
    i_divisor  = BW'(b);
    if (track) begin
      e = '{a: a, b: b, q: q, r: r, dz: dz, acc: cyc + 1};
      sb.push_back(e);
    end
    @(negedge i_clk);
    i_start = 1'b0;
    check("busy_after_accept", int'(o_busy), 1);
  endtask

  task automatic drain();
    int w = 0;
    while ((sb.size() != 0 || o_busy) && w < 40) begin
      @(negedge i_clk);
      w++;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, d0;
    int a, b;
    exp_t e;

    // Reset state
    #12;
    check("rst_busy", int'(o_busy), 0);
    check("rst_done", int'(o_done), 0);
    check("rst_quotient", int'(o_quotient), 0);
    check("rst_remainder", int'(o_remainder), 0);
    check("rst_dbz", int'(o_div_by_zero), 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // 100/7 with busy-length measurement
    issue(100, 7, 14, 2, 0, 1'b1);
    n = 1;
    while (n < 50) begin
      @(negedge i_clk);
      if (!o_busy) break;
      n++;
    end
    check("busy_cycles", n, BW + 1);
    check("done_after_busy", int'(o_done), 0);

    issue(255, 1, 255, 0, 0, 1'b1);
    issue(3, 10, 0, 3, 0, 1'b1);
    issue(200, 200, 1, 0, 0, 1'b1);
    issue(5, 0, 255, 5, 1, 1'b1);
    issue(9, 3, 3, 0, 0, 1'b1);
    drain();
    check("dbz_hold", int'(o_div_by_zero), 0);

    // Start pulse and operand changes during CALC are ignored
    d0 = done_count;
    issue(100, 7, 14, 2, 0, 1'b1);
    @(negedge i_clk);
    @(negedge i_clk);
    i_start = 1'b1; i_dividend = 8'd50; i_divisor = 8'd5;
    @(negedge i_clk);
    i_start = 1'b0; i_dividend = 8'd3; i_divisor = 8'd1;
    drain();
    check("single_done", done_count - d0, 1);
    check("result_hold_q", int'(o_quotient), 14);

    // Asynchronous reset after four iterations discards the division
    issue(100, 7, 0, 0, 0, 1'b0);
    repeat (4) @(negedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    check("midrst_busy", int'(o_busy), 0);
    check("midrst_done", int'(o_done), 0);
    check("midrst_quotient", int'(o_quotient), 0);
    check("midrst_remainder", int'(o_remainder), 0);
    check("midrst_dbz", int'(o_div_by_zero), 0);
    d0 = done_count;
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (12) @(negedge i_clk);
    check("midrst_no_done", done_count - d0, 0);
    issue(77, 4, 19, 1, 0, 1'b1);
    drain();

    // Back-to-back divisions with i_start held high
    i_start = 1'b1;
    last_acc = -1;
    for (int i = 0; i < 1000; i++) begin
      n = 0;
      while (o_busy && n < 40) begin
        @(negedge i_clk);
        n++;
      end
      a = $urandom_range(0, 255);
      b = (i % 50 == 0) ? 0 : $urandom_range(0, 255);
      i_dividend = BW'(a);
      i_divisor  = BW'(b);
      e.a = a; e.b = b; e.acc = cyc + 1;
      e.q  = (b == 0) ? 255 : a / b;
      e.r  = (b == 0) ? a : a % b;
      e.dz = (b == 0) ? 1 : 0;
      sb.push_back(e);
      if (last_acc >= 0 && (e.acc - last_acc) != BW + 2)
        check("b2b_spacing", e.acc - last_acc, BW + 2);
      last_acc = e.acc;
      @(negedge i_clk);
    end
    i_start = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
